// File: rtl/tft_ctrl.sv
// -----------------------------------------------------------------------------
// tft_ctrl
//
// Timing controller for a 480x272 RGB565 TFT panel. It generates the
// horizontal and vertical scan counters, the hsync/vsync pulses and the panel
// data enable. It also requests pixels from an upstream pixel source.
//
// The request (pix_x/pix_y) is issued one clock ahead of the active window.
// The pixel source answers with registered pix_data one clock later, so that
// data lines up exactly with the active window on rgb_tft.
//
// The first (partial) frame after reset is blanked. Both tft_de and the RGB
// bus stay low until one complete frame has been scanned. The backlight is
// switched on at that same point.
//
// Ports
//   tft_clk      in   pixel clock
//   sys_rst_n    in   asynchronous active-low reset
//   pix_data     in   [15:0] RGB565 from pixel source, 1 clock after request
//   pix_x        out  [9:0]  requested column, 10'h3FF when idle
//   pix_y        out  [9:0]  requested row, 10'h3FF when idle
//   rgb_tft      out  [15:0] panel RGB565 bus (black outside active area)
//   hsync        out  horizontal sync, active high
//   vsync        out  vertical sync, active high
//   tft_clk_out  out  panel clock (straight copy of tft_clk)
//   tft_de       out  panel data enable
//   tft_bl       out  backlight enable
//   frame_end    out  one-clock pulse following the last active pixel
// -----------------------------------------------------------------------------
module tft_ctrl #(
    parameter logic [9:0] H_SYNC  = 10'd41,
    parameter logic [9:0] H_BACK  = 10'd2,
    parameter logic [9:0] H_VALID = 10'd480,
    parameter logic [9:0] H_FRONT = 10'd2,
    parameter logic [9:0] H_TOTAL = 10'd525,
    parameter logic [9:0] V_SYNC  = 10'd10,
    parameter logic [9:0] V_BACK  = 10'd2,
    parameter logic [9:0] V_VALID = 10'd272,
    parameter logic [9:0] V_FRONT = 10'd2,
    parameter logic [9:0] V_TOTAL = 10'd286
) (
    input  logic        tft_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] rgb_tft,
    output logic        hsync,
    output logic        vsync,
    output logic        tft_clk_out,
    output logic        tft_de,
    output logic        tft_bl,
    output logic        frame_end
);

    // Window boundaries. The active region ends where the front porch begins.
    // The request window is the active window shifted one clock earlier.
    localparam logic [9:0] H_LAST      = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST      = V_TOTAL - 10'd1;
    localparam logic [9:0] H_ACT_START = H_SYNC + H_BACK;
    localparam logic [9:0] H_ACT_END   = H_TOTAL - H_FRONT - 10'd1;
    localparam logic [9:0] V_ACT_START = V_SYNC + V_BACK;
    localparam logic [9:0] V_ACT_END   = V_TOTAL - V_FRONT - 10'd1;
    localparam logic [9:0] H_REQ_START = H_ACT_START - 10'd1;
    localparam logic [9:0] H_REQ_END   = H_ACT_START + H_VALID - 10'd2;
    localparam logic [9:0] V_VAL_END   = V_ACT_START + V_VALID - 10'd1;

    logic [9:0] cnt_h_reg;
    logic [9:0] cnt_v_reg;
    logic       de_arm_reg;
    logic       tft_bl_reg;
    logic       frame_end_reg;

    logic       line_last;
    logic       frame_last;
    logic       h_act;
    logic       v_act;
    logic       rgb_valid;
    logic       pix_req;

    assign line_last  = (cnt_h_reg == H_LAST);
    assign frame_last = line_last && (cnt_v_reg == V_LAST);

    // ---------------------------------------------------------------------
    // Scan counters. The vertical counter advances on the last clock of
    // each line. On the last line of the frame, both counters wrap on the
    // same edge.
    // ---------------------------------------------------------------------
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_reg <= 10'd0;
        end else if (line_last) begin
            cnt_h_reg <= 10'd0;
        end else begin
            cnt_h_reg <= cnt_h_reg + 10'd1;
        end
    end

    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_v_reg <= 10'd0;
        end else if (frame_last) begin
            cnt_v_reg <= 10'd0;
        end else if (line_last) begin
            cnt_v_reg <= cnt_v_reg + 10'd1;
        end
    end

    // ---------------------------------------------------------------------
    // de_arm and the backlight enable are sticky. They set when the first
    // complete frame after reset finishes, so the partial frame that was
    // in flight at reset release is never shown. Only a reset clears them.
    // ---------------------------------------------------------------------
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de_arm_reg <= 1'b0;
            tft_bl_reg <= 1'b0;
        end else if (frame_last) begin
            de_arm_reg <= 1'b1;
            tft_bl_reg <= 1'b1;
        end
    end

    // frame_end is registered off the last active pixel. It therefore
    // appears one clock later, on the first front-porch clock of the last
    // active line.
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_end_reg <= 1'b0;
        end else begin
            frame_end_reg <= (cnt_h_reg == H_ACT_END) && (cnt_v_reg == V_ACT_END);
        end
    end

    // ---------------------------------------------------------------------
    // Combinational decode from the counters.
    // ---------------------------------------------------------------------
    assign hsync     = (cnt_h_reg <= H_SYNC - 10'd1);
    assign vsync     = (cnt_v_reg <= V_SYNC - 10'd1);

    assign h_act     = (cnt_h_reg >= H_ACT_START) && (cnt_h_reg <= H_ACT_END);
    assign v_act     = (cnt_v_reg >= V_ACT_START) && (cnt_v_reg <= V_VAL_END);
    assign rgb_valid = h_act && v_act;

    assign pix_req   = v_act && (cnt_h_reg >= H_REQ_START) && (cnt_h_reg <= H_REQ_END);

    // The subtraction is only taken inside the request window, so the
    // result is always in range. Outside the window, the all-ones
    // coordinate tells the pixel source that no request is pending.
    assign pix_x = pix_req ? (cnt_h_reg - H_REQ_START) : 10'h3FF;
    assign pix_y = pix_req ? (cnt_v_reg - V_ACT_START) : 10'h3FF;

    // Black is driven outside the active area and throughout the blanked
    // first frame.
    assign rgb_tft     = (rgb_valid && de_arm_reg) ? pix_data : 16'h0000;
    assign tft_de      = rgb_valid && de_arm_reg;
    assign tft_bl      = tft_bl_reg;
    assign frame_end   = frame_end_reg;
    assign tft_clk_out = tft_clk;

endmodule

// File: tb/tb_tft_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tft_ctrl
//
// Two instances share clock and reset:
//   dut      - a shrunken panel timing (24 x 15 clocks per frame), so that
//              many complete frames, the first-frame blanking and mid-frame
//              resets all fit in a short run.
//   dut_full - default 480x272 timing, checked over its first lines.
//
// The expected outputs come from a time-based reference. Position in the
// frame is derived from the number of clocks since reset release, using
// div/mod arithmetic. Each instance is driven by its own pixel source.
// A request returns {pix_y[5:0], pix_x} on the next clock; when there is no
// request, the pixel source drives random data, so any leak past the
// blanking logic is visible.
// -----------------------------------------------------------------------------
module tb_tft_ctrl;

    localparam int SHS = 4,  SHB = 2, SHV = 16,  SHF = 2, SHT = 24;
    localparam int SVS = 3,  SVB = 2, SVV = 8,   SVF = 2, SVT = 15;
    localparam int FHS = 41, FHB = 2, FHV = 480, FHT = 525;
    localparam int FVS = 10, FVB = 2, FVV = 272, FVT = 286;
    localparam int FRAME_S = SHT * SVT;

    logic        tft_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;

    logic [15:0] pix_data_s, pix_data_f;
    logic [15:0] pend_s, pend_f;
    logic [9:0]  pix_x_s, pix_y_s, pix_x_f, pix_y_f;
    logic [15:0] rgb_s, rgb_f;
    logic        hs_s, vs_s, clko_s, de_s, bl_s, fe_s;
    logic        hs_f, vs_f, clko_f, de_f, bl_f, fe_f;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;   // clocks since reset release

    always #5 tft_clk = ~tft_clk;

    tft_ctrl #(
        .H_SYNC (10'(SHS)), .H_BACK (10'(SHB)), .H_VALID(10'(SHV)),
        .H_FRONT(10'(SHF)), .H_TOTAL(10'(SHT)),
        .V_SYNC (10'(SVS)), .V_BACK (10'(SVB)), .V_VALID(10'(SVV)),
        .V_FRONT(10'(SVF)), .V_TOTAL(10'(SVT))
    ) dut (
        .tft_clk    (tft_clk),
        .sys_rst_n  (sys_rst_n),
        .pix_data   (pix_data_s),
        .pix_x      (pix_x_s),
        .pix_y      (pix_y_s),
        .rgb_tft    (rgb_s),
        .hsync      (hs_s),
        .vsync      (vs_s),
        .tft_clk_out(clko_s),
        .tft_de     (de_s),
        .tft_bl     (bl_s),
        .frame_end  (fe_s)
    );

    tft_ctrl dut_full (
        .tft_clk    (tft_clk),
        .sys_rst_n  (sys_rst_n),
        .pix_data   (pix_data_f),
        .pix_x      (pix_x_f),
        .pix_y      (pix_y_f),
        .rgb_tft    (rgb_f),
        .hsync      (hs_f),
        .vsync      (vs_f),
        .tft_clk_out(clko_f),
        .tft_de     (de_f),
        .tft_bl     (bl_f),
        .frame_end  (fe_f)
    );

    // Pixel sources: capture the request mid-cycle, then present the answer
    // just after the next rising edge (registered one-clock latency).
    initial begin
        forever begin
            @(negedge tft_clk);
            pend_s = (pix_x_s != 10'h3FF) ? {pix_y_s[5:0], pix_x_s} : 16'($urandom);
            pend_f = (pix_x_f != 10'h3FF) ? {pix_y_f[5:0], pix_x_f} : 16'($urandom);
        end
    end

    initial begin
        pix_data_s = 16'h0;
        pix_data_f = 16'h0;
        forever begin
            @(posedge tft_clk);
            #1;
            pix_data_s = pend_s;
            pix_data_f = pend_f;
        end
    end

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic        bl;
        logic        fe;
    } exp_t;

    // Expected outputs tc clocks after reset release. tc == 0 also describes
    // the state held during reset.
    function automatic exp_t model(input int tc, input int hs, input int hb,
                                   input int hv, input int ht, input int vs,
                                   input int vb, input int vv, input int vt);
        exp_t e;
        int   h, v, ph, pv, ha0, va0;
        bit   armed, hact, vact, req;
        ha0   = hs + hb;
        va0   = vs + vb;
        h     = tc % ht;
        v     = (tc / ht) % vt;
        armed = (tc / (ht * vt)) >= 1;
        vact  = (v >= va0) && (v < va0 + vv);
        hact  = (h >= ha0) && (h < ha0 + hv);
        req   = vact && (h >= ha0 - 1) && (h < ha0 + hv - 1);
        e.x   = req ? 10'(h - ha0 + 1) : 10'h3FF;
        e.y   = req ? 10'(v - va0) : 10'h3FF;
        e.hs  = (h < hs);
        e.vs  = (v < vs);
        e.bl  = armed;
        e.de  = hact && vact && armed;
        e.rgb = e.de ? {6'(v - va0), 10'(h - ha0)} : 16'h0000;
        e.fe  = 1'b0;
        if (tc > 0) begin
            ph   = (tc - 1) % ht;
            pv   = ((tc - 1) / ht) % vt;
            e.fe = (ph == ha0 + hv - 1) && (pv == va0 + vv - 1);
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d @%0t: got %0h expected %0h", tag, t, $time, got, exp);
        end
    endtask

    task automatic compare_now();
        exp_t es, ef;
        es = model(t, SHS, SHB, SHV, SHT, SVS, SVB, SVV, SVT);
        ef = model(t, FHS, FHB, FHV, FHT, FVS, FVB, FVV, FVT);
        check("s.pix_x",   32'(pix_x_s), 32'(es.x));
        check("s.pix_y",   32'(pix_y_s), 32'(es.y));
        check("s.rgb",     32'(rgb_s),   32'(es.rgb));
        check("s.hsync",   32'(hs_s),    32'(es.hs));
        check("s.vsync",   32'(vs_s),    32'(es.vs));
        check("s.de",      32'(de_s),    32'(es.de));
        check("s.bl",      32'(bl_s),    32'(es.bl));
        check("s.fe",      32'(fe_s),    32'(es.fe));
        check("s.clk_out", 32'(clko_s),  32'(tft_clk));
        check("f.pix_x",   32'(pix_x_f), 32'(ef.x));
        check("f.pix_y",   32'(pix_y_f), 32'(ef.y));
        check("f.rgb",     32'(rgb_f),   32'(ef.rgb));
        check("f.hsync",   32'(hs_f),    32'(ef.hs));
        check("f.vsync",   32'(vs_f),    32'(ef.vs));
        check("f.de",      32'(de_f),    32'(ef.de));
        check("f.bl",      32'(bl_f),    32'(ef.bl));
        check("f.fe",      32'(fe_f),    32'(ef.fe));
    endtask

    // Called at a falling edge; returns at a falling edge n clocks later.
    task automatic run_cycles(input int n);
        int fe_seen;
        fe_seen = 0;
        for (int i = 0; i < n; i++) begin
            compare_now();
            if (fe_s) fe_seen++;
            @(posedge tft_clk);
            t++;
            @(negedge tft_clk);
        end
        $display("run: %0d clocks, now t=%0d, small frame_end pulses seen %0d", n, t, fe_seen);
    endtask

    // Reset is asserted mid-cycle. The outputs must fall back at once,
    // without waiting for a clock edge.
    task automatic apply_reset(input int n);
        sys_rst_n = 1'b0;
        #1;
        t = 0;
        compare_now();
        for (int i = 0; i < n; i++) begin
            @(posedge tft_clk);
            @(negedge tft_clk);
            compare_now();
        end
        sys_rst_n = 1'b1;
        t = 0;
        $display("reset: held %0d clocks, released", n);
    endtask

    initial begin
        int gap;
        // Power-on reset for 5 clocks; every cycle shows the reset state.
        for (int i = 0; i < 5; i++) begin
            @(negedge tft_clk);
            t = 0;
            compare_now();
        end
        sys_rst_n = 1'b1;
        t = 0;
        $display("reset: power-on, released after 5 clocks");

        // Blank first frame, then two displayed frames.
        run_cycles(3 * FRAME_S + 17);

        // Stop inside the active area of an armed frame (line 5, column 10),
        // then reset for 3 clocks.
        gap = (FRAME_S + 5 * SHT + 10 - (t % FRAME_S)) % FRAME_S;
        run_cycles(gap);
        check("pre_reset.de", 32'(de_s), 32'd1);
        apply_reset(3);
        run_cycles(FRAME_S + 5);

        // Randomly timed resets of random length.
        for (int k = 0; k < 4; k++) begin
            run_cycles(int'($urandom_range(40, 2 * FRAME_S)));
            apply_reset(int'($urandom_range(1, 4)));
        end

        // A long final run. It spans many small frames and the first
        // 17 lines of the full-size timing.
        run_cycles(9000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tft_ctrl.md
Name: tft_ctrl

Overview:
- TFT timing controller for the 480x272 RGB565 panel.
- Generates horizontal and vertical counters, hsync/vsync and DE.
- Issues pixel coordinates (pix_x/pix_y) one clock ahead to the pixel-source block, which returns registered pix_data one clock later.
- Drives the panel RGB bus with pix_data during the active area and black elsewhere.
- Sits between the pixel generator and the panel pins.

Parameters:
- H_SYNC, 10'd41, hsync pulse width (clocks)
- H_BACK, 10'd2, horizontal back porch
- H_VALID, 10'd480, active pixels per line
- H_FRONT, 10'd2, horizontal front porch
- H_TOTAL, 10'd525, line period (sum of the four above)
- V_SYNC, 10'd10, vsync pulse width (lines)
- V_BACK, 10'd2, vertical back porch
- V_VALID, 10'd272, active lines
- V_FRONT, 10'd2, vertical front porch
- V_TOTAL, 10'd286, frame period in lines

Ports:
- tft_clk  input  1  pixel clock (9 MHz); asynchronous reset domain below
- sys_rst_n  input  1  reset, asynchronous, active-low
- pix_data  input  16  RGB565 from pixel source, valid 1 clock after pix_x/pix_y
- pix_x  output  10  requested column 0..479; 10'h3FF when no request
- pix_y  output  10  requested row 0..271; 10'h3FF when no request
- rgb_tft  output  16  panel RGB565 data
- hsync  output  1  horizontal sync, active high
- vsync  output  1  vertical sync, active high
- tft_clk_out  output  1  panel clock, equal to tft_clk
- tft_de  output  1  panel data enable
- tft_bl  output  1  backlight enable
- frame_end  output  1  one-clock pulse, last active pixel of each frame

Behaviour:
- Horizontal counter cnt_h:
  - 10-bit, reset 0, increments every clock.
  - Wraps H_TOTAL-1 -> 0.
- Vertical counter cnt_v:
  - 10-bit, reset 0, increments only when cnt_h == H_TOTAL-1.
  - Wraps V_TOTAL-1 -> 0 on that same clock.
- Sync signals:
  - hsync = (cnt_h <= H_SYNC-1).
  - vsync = (cnt_v <= V_SYNC-1).
  - Both are combinational from the counters, so both read 1 in reset.
- Active window:
  - h_act = cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1], i.e. [43, 522].
  - v_act = cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID-1], i.e. [12, 283].
  - rgb_valid = h_act && v_act.
- Request window:
  - pix_req = v_act && cnt_h in [H_SYNC+H_BACK-1, H_SYNC+H_BACK+H_VALID-2], i.e. [42, 521].
  - This is exactly one clock ahead of rgb_valid.
  - pix_x = pix_req ? cnt_h-(H_SYNC+H_BACK-1) : 10'h3FF.
  - pix_y = pix_req ? cnt_v-(V_SYNC+V_BACK) : 10'h3FF.
  - Subtraction is 10-bit unsigned, evaluated only inside the window.
  - The pair (479,271) appears exactly once per frame, for one clock.
- Output data: rgb_tft = rgb_valid ? pix_data : 16'h0000, combinational.
- First-frame blanking:
  - Register de_arm: reset 0, set to 1 on the clock where cnt_h == H_TOTAL-1 and cnt_v == V_TOTAL-1, then stays 1 until the next reset.
  - tft_de = rgb_valid && de_arm.
  - rgb_tft is forced to 0 while de_arm == 0, so the first partial frame after reset is never shown.
- Backlight: tft_bl is registered, reset 0, and goes to 1 on the same clock de_arm sets.
- frame_end:
  - Registered, reset 0.
  - Asserted for one clock on the clock after cnt_h == 522 and cnt_v == 283, i.e. coincident with cnt_h == 523.
- Reset mid-frame:
  - All registers return to reset values immediately and asynchronously.
  - Counters restart at 0.
  - de_arm clears, so one full blank frame follows before display resumes.
- Simultaneous line and frame wrap (cnt_h == 524, cnt_v == 285): both counters go to 0 on the same edge.
- tft_clk_out is a direct assign, not gated.

Test Plan:
- Reset held 5 clocks, then released:
  - cnt_h/cnt_v = 0, tft_de = 0, tft_bl = 0, rgb_tft = 0, pix_x = pix_y = 3FF during reset.
  - hsync = 1, vsync = 1 during reset.
- Run 2 frames (300300 clocks):
  - hsync high for exactly 41 clocks per 525-clock line.
  - vsync high for exactly 10 lines of 286.
  - Frame length 150150 clocks.
- Coordinate timing with a pixel-source model that registers pix_data = {pix_y[5:0], pix_x} one clock after the request:
  - In frame 2 at cnt_v = 12, cnt_h = 42: pix_x = 0 and pix_y = 0.
  - At cnt_h = 43: tft_de = 1 and rgb_tft = 16'h0000.
  - At cnt_h = 522: rgb_tft = 16'h01DF.
  - At cnt_h = 523: tft_de = 0.
- First frame after reset:
  - tft_de never asserts; tft_bl rises at the cnt_h = 524, cnt_v = 285 edge.
  - frame_end still pulses once, at cnt_v = 283, cnt_h = 523.
- End-of-frame checks:
  - pix_x = 479, pix_y = 271 occurs exactly once per frame.
  - frame_end pulses exactly once per frame, 1 clock wide.
- Reset asserted at cnt_v = 100, cnt_h = 200 for 3 clocks:
  - Counters restart at 0 and tft_de/tft_bl drop immediately.
  - Display re-enables only after the next full frame (150150 clocks).
